// File: rtl/cntlr_tx.sv
// Joybus command transmitter: serialises a command onto the open-drain
// line, appends the console stop bit and hands the line to the receiver.
module cntlr_tx #(
  parameter int CYC_PER_US = 25,
  parameter int MAX_BITS   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_start,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [4:0]          tx_nbits,
  output logic                tx_busy,
  output logic                tx_done,
  output logic                rx_start,
  output logic                JB_TX_OE
);

  localparam int CW = $clog2(4*CYC_PER_US+1);
  localparam logic [CW-1:0] SHORT = CW'(CYC_PER_US-1);
  localparam logic [CW-1:0] LONG  = CW'(3*CYC_PER_US-1);
  localparam logic [4:0]    NMAX  = 5'(MAX_BITS);

  typedef enum logic [2:0] {
    IDLE,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW,
    DONE
  } state_t;

  state_t              state;
  logic [MAX_BITS-1:0] shreg;
  logic [4:0]          nleft;
  logic [CW-1:0]       cnt;
  logic                bit_now;
  logic [4:0]          nclamp;

  assign bit_now = shreg[MAX_BITS-1];
  assign nclamp  = (tx_nbits > NMAX) ? NMAX : tx_nbits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      JB_TX_OE <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      rx_start <= 1'b0;
      shreg    <= '0;
      nleft    <= '0;
      cnt      <= '0;
    end else begin
      tx_done  <= 1'b0;
      rx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            shreg    <= tx_data;
            nleft    <= nclamp;
            cnt      <= '0;
            JB_TX_OE <= 1'b1;
            tx_busy  <= 1'b1;
            state    <= (nclamp == 5'd0) ? STOP_LOW : BIT_LOW;
          end
        end
        BIT_LOW: begin
          // a '1' is a short low pulse, a '0' a long one
          if (cnt == (bit_now ? SHORT : LONG)) begin
            cnt      <= '0;
            JB_TX_OE <= 1'b0;
            state    <= BIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BIT_HIGH: begin
          if (cnt == (bit_now ? LONG : SHORT)) begin
            cnt      <= '0;
            JB_TX_OE <= 1'b1;
            shreg    <= {shreg[MAX_BITS-2:0], 1'b0};
            nleft    <= nleft - 5'd1;
            state    <= (nleft == 5'd1) ? STOP_LOW : BIT_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP_LOW: begin
          if (cnt == SHORT) begin
            cnt      <= '0;
            JB_TX_OE <= 1'b0;
            tx_done  <= 1'b1;
            rx_start <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
